// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_pkg
// Description : Shared constants for the sequential signed/unsigned
//               multiplier: FSM state encoding, default operand widths and
//               the step-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // FSM state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Default operand widths
  localparam int c_def_n = 4;
  localparam int c_def_m = 4;

  // ceil(log2(m)), never below one bit so the counter always exists
  function automatic int cnt_width(input int m);
    int w;
    w = 1;
    while ((1 << w) < m) w++;
    return w;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/seq_signed_multiplier_addsub.sv
`default_nettype none
// ============================================================================
// Module      : rca / addsub
// Description : rca is a plain W-bit ripple-carry adder. addsub wraps it to
//               form a W-bit add/subtract: y = a + b (sub=0) or a - b (sub=1),
//               by inverting b and feeding sub in as the carry.
//               All results wrap modulo 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic w_c;

  // Ripple the carry bit by bit; the final carry-out is dropped (modulo 2^W)
  always_comb begin
    w_c = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
  end

endmodule : rca

module addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic [W-1:0] w_b;

  // Two's-complement negate of b when subtracting: ~b here, +1 via carry-in
  always_comb begin
    w_b = b ^ {W{sub}};
  end

  rca #(.W(W)) u_rca (
    .a   (a),
    .b   (w_b),
    .cin (sub),
    .sum (y)
  );

endmodule : addsub
`default_nettype wire

// File: rtl/seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_multiplier
// Description : Shift-and-add multiplier, one multiplier bit per cycle.
//               N-bit A times M-bit B gives an exact N+M bit product in either
//               unsigned or two's-complement mode. Fixed latency of M cycles,
//               valid/ready handshake on both sides, single shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_multiplier
  import mult_pkg::*;
#(
  parameter int N = c_def_n,
  parameter int M = c_def_m
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   B,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] P
);

  localparam int W  = N + M;
  localparam int CW = cnt_width(M);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mcand;   // A extended, shifted left once per step (A << k)
  logic [M-1:0]  r_mplier;  // B, shifted right once per step (bit 0 = B[k])
  logic          r_signed;

  logic          w_accept;
  logic          w_last;
  logic          w_sub;
  logic [W-1:0]  w_pp;
  logic [W-1:0]  w_sum;

  // Handshake, step decode and partial-product selection
  always_comb begin
    in_ready  = (r_state == c_st_idle);
    out_valid = (r_state == c_st_done);
    w_accept  = in_valid & in_ready;
    w_last    = (r_cnt == CW'(M - 1));
    // In signed mode the top multiplier bit carries weight -2^(M-1)
    w_sub     = r_signed & w_last;
    w_pp      = r_mplier[0] ? r_mcand : '0;
    P         = r_acc;
  end

  addsub #(.W(W)) u_addsub (
    .a   (r_acc),
    .b   (w_pp),
    .sub (w_sub),
    .y   (w_sum)
  );

  // Control: IDLE -> CALC on accept, CALC -> DONE after M steps, DONE -> IDLE on take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state <= c_st_calc;
            r_cnt   <= '0;
          end
        end
        c_st_calc: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= c_st_done;
        end
        c_st_done: begin
          if (out_ready) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Datapath: capture operands on accept, accumulate one partial product per CALC step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{M{signed_mode & A[N-1]}}, A};
      r_mplier <= B;
      r_signed <= signed_mode;
    end else if (r_state == c_st_calc) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule : seq_signed_multiplier
`default_nettype wire

// File: tb/tb_seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_signed_multiplier
// Description : Self-checking bench: directed cases on a 4x4 instance,
//               randomized sweep on a 5x7 instance against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc7 = -1;

  // 4x4 instance
  logic       iv4 = 1'b0, or4 = 1'b0, sm4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4;
  logic [7:0] p4;

  // 5x7 instance
  logic        iv7 = 1'b0, or7 = 1'b0, sm7 = 1'b0;
  logic [4:0]  a7 = '0;
  logic [6:0]  b7 = '0;
  logic        ir7, ov7;
  logic [11:0] p7;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_multiplier #(.N(4), .M(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .P(p4)
  );

  seq_signed_multiplier #(.N(5), .M(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7), .A(a7), .B(b7),
    .signed_mode(sm7), .out_valid(ov7), .out_ready(or7), .P(p7)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers, multiply, wrap to n+m bits
  function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                           input logic sm, input int n, input int m);
    longint x, y;
    x = longint'(a);
    y = longint'(b);
    if (sm && a[n-1]) x = x - (longint'(1) << n);
    if (sm && b[m-1]) y = y - (longint'(1) << m);
    return 64'(x * y) & ((64'(1) << (n + m)) - 64'(1));
  endfunction

  // Present an op to the 4x4 instance (currently IDLE) and pass the accept edge
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    iv4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm;
    chk_eq("busy_after_accept", {63'd0, ir4}, 64'd0);
  endtask

  // Wait for result, hold it for 'hold' cycles, take it; optionally keep a new op pending
  task automatic finish4(input logic [7:0] exp, input int hold, input logic pend,
                         input logic [3:0] pa, input logic [3:0] pb, input logic psm);
    int n;
    n = 0;
    while (!ov4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk_eq("latency4", 64'(n), 64'd4);
    chk_eq("p4", {56'd0, p4}, {56'd0, exp});
    if (pend) begin
      iv4 = 1'b1; a4 = pa; b4 = pb; sm4 = psm;
    end
    or4 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_eq("hold_p4", {56'd0, p4}, {56'd0, exp});
      chk_eq("hold_ov4", {63'd0, ov4}, 64'd1);
      chk_eq("hold_ir4", {63'd0, ir4}, 64'd0);
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk_eq("xfer_ov4", {63'd0, ov4}, 64'd0);
    chk_eq("xfer_ir4", {63'd0, ir4}, 64'd1);
    if (pend) begin
      @(posedge clk); #1;
      chk_eq("next_accept4", {63'd0, ir4}, 64'd0);
      iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~psm;
    end
  endtask

  // One randomized op on the 5x7 instance with random backpressure
  task automatic run7();
    logic [4:0]  a;
    logic [6:0]  b;
    logic        sm, r;
    logic [11:0] e;
    int n, t0, k;
    a = 5'($urandom); b = 7'($urandom); sm = 1'($urandom_range(0, 1));
    e = 12'(ref_prod(64'(a), 64'(b), sm, 5, 7));
    iv7 = 1'b1; a7 = a; b7 = b; sm7 = sm;
    @(posedge clk); #1;
    t0 = cyc;
    iv7 = 1'b0; a7 = 5'($urandom); b7 = 7'($urandom); sm7 = ~sm;
    if (last_acc7 >= 0) chk_eq("interval7", 64'(t0 - last_acc7 >= 9), 64'd1);
    last_acc7 = t0;
    n = 0;
    while (!ov7 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk_eq("latency7", 64'(n), 64'd7);
    chk_eq("p7", {52'd0, p7}, {52'd0, e});
    k = 0;
    r = 1'b0;
    while (!r) begin
      r = (k >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      or7 = r;
      @(posedge clk); #1;
      k++;
      if (!r) begin
        chk_eq("hold_p7", {52'd0, p7}, {52'd0, e});
        chk_eq("hold_ov7", {63'd0, ov7}, 64'd1);
      end
    end
    or7 = 1'b0;
    chk_eq("xfer_ov7", {63'd0, ov7}, 64'd0);
    chk_eq("xfer_ir7", {63'd0, ir7}, 64'd1);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ovc;
    vecs[0] = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[1] = '{4'h7, 4'h8, 1'b1, 8'hC8};
    vecs[2] = '{4'h7, 4'h8, 1'b0, 8'h38};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[5] = '{4'h0, 4'h5, 1'b1, 8'h00};
    vecs[6] = '{4'h3, 4'h0, 1'b0, 8'h00};
    vecs[7] = '{4'h5, 4'hD, 1'b1, 8'hF1};

    // Reset state
    #12;
    chk_eq("rst_p4", {56'd0, p4}, 64'd0);
    chk_eq("rst_ov4", {63'd0, ov4}, 64'd0);
    chk_eq("rst_ir4", {63'd0, ir4}, 64'd1);
    chk_eq("rst_p7", {52'd0, p7}, 64'd0);
    chk_eq("rst_ir7", {63'd0, ir7}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    foreach (vecs[i]) begin
      start4(vecs[i].a, vecs[i].b, vecs[i].sm);
      finish4(vecs[i].p, 0, 1'b0, 4'h0, 4'h0, 1'b0);
    end

    // Backpressure with a pending op (-3 * 6 = -18 = 8'hEE)
    start4(4'h7, 4'h8, 1'b1);
    finish4(8'hC8, 5, 1'b1, 4'hD, 4'h6, 1'b1);
    finish4(8'hEE, 0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of CALC
    start4(4'hF, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_p4", {56'd0, p4}, 64'd0);
    chk_eq("midrst_ov4", {63'd0, ov4}, 64'd0);
    chk_eq("midrst_ir4", {63'd0, ir4}, 64'd1);
    iv4 = 1'b1; a4 = 4'h3; b4 = 4'h3;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("inrst_ir4", {63'd0, ir4}, 64'd1);
    chk_eq("inrst_p4", {56'd0, p4}, 64'd0);
    iv4 = 1'b0;
    rst_n = 1'b1;
    ovc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov4) ovc++;
    end
    chk_eq("no_ov_after_rst", 64'(ovc), 64'd0);
    start4(4'h9, 4'h3, 1'b1);
    finish4(8'hEB, 0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Randomized sweep on the 5x7 instance
    for (int i = 0; i < 60; i++) run7();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_seq_signed_multiplier
`default_nettype wire

// File: doc/seq_signed_multiplier.md
SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 Parameter N, default 4: width of multiplicand A; N >= 2.
REQ-002 Parameter M, default 4: width of multiplier B and number of compute cycles; M >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands A, B, signed_mode are valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 A  input  N  multiplicand.
REQ-008 B  input  M  multiplier.
REQ-009 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-010 out_valid  output  1  P holds a finished product.
REQ-011 out_ready  input  1  consumer takes P this cycle.
REQ-012 P  output  N+M  product.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with in_valid && in_ready.
- Captures A, B and signed_mode.
- Clears the accumulator and the step counter.
- Moves to CALC.
REQ-016 Operand inputs SHALL be ignored outside the accept edge; later input changes SHALL not affect the in-flight operation.
REQ-017 In CALC, each edge SHALL process exactly one bit B[k], for k = 0..M-1 in order.
- Partial product = B[k] ? (A extended to N+M bits) << k : 0.
- A is sign-extended when signed_mode = 1 and zero-extended when signed_mode = 0.
REQ-018 All partial products SHALL be added into the accumulator, with one exception.
- Exception: when signed_mode = 1 and k = M-1, the partial product SHALL be subtracted.
- All arithmetic is modulo 2^(N+M).
REQ-019 The step counter SHALL be ceil(log2(M)) bits wide and SHALL increment once per CALC edge.
- On the edge processing k = M-1, the FSM SHALL move to DONE.
REQ-020 out_valid SHALL rise exactly M cycles after the accept edge.
REQ-021 P SHALL equal the exact product A*B, in the chosen interpretation, in N+M bits.
REQ-022 In DONE, P and out_valid SHALL stay stable while out_ready = 0, for unbounded backpressure.
REQ-023 DONE with out_ready = 1 SHALL complete the transfer and return to IDLE; the earliest next accept is the following edge.
- Minimum issue interval is M+2 cycles.
REQ-024 The extreme cases SHALL be exact: signed (-2^(N-1))*(-2^(M-1)) = +2^(N+M-2) and unsigned (2^N-1)*(2^M-1); no saturation, no overflow flag.
REQ-025 B = 0 or A = 0 SHALL still take the full M cycles, giving a fixed latency.
REQ-026 in_valid asserted in CALC or DONE SHALL be neither captured nor lost-tracked; the upstream holds it until in_ready = 1.

Reset
REQ-027 rst_n = 0 SHALL immediately, without a clock, force all of the following:
- FSM to IDLE;
- P = 0;
- out_valid = 0;
- accumulator, counter and operand registers to 0.
REQ-028 During reset, in_ready SHALL be 1 (IDLE), but no accept SHALL occur while rst_n = 0.
REQ-029 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no out_valid pulse follows.

Structure
REQ-030 A shared package mult_pkg SHALL hold:
- FSM state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2);
- default N and M;
- the counter-width function.
REQ-031 One sub-module is natural: addsub, an (N+M)-bit add/subtract built on the existing ripple-carry adder RCA (inverted operand, carry-in = sub). The block SHALL instantiate it once.
REQ-032 The design SHALL contain no multiplier operator and no combinational array; datapath cost is one (N+M)-bit adder.

Verification (N = M = 4 unless stated)
REQ-033 Signed, A = 4'h8 (-8), B = 4'h8 (-8) -> out_valid 4 cycles after accept, P = 8'h40.
REQ-034 Signed, A = 4'h7, B = 4'h8 -> P = 8'hC8 (-56); unsigned with the same operands -> P = 8'h38 (56).
REQ-035 Unsigned, A = 4'hF, B = 4'hF -> P = 8'hE1; signed with the same operands -> P = 8'h01.
REQ-036 Backpressure: hold out_ready = 0 for 5 cycles in DONE with a new in_valid pending -> P, out_valid stable, in_ready = 0; release -> IDLE, next accept the following edge.
REQ-037 Pull rst_n low at CALC step 2 -> immediate P = 0, out_valid = 0, state IDLE; after release, a new op completes correctly.
REQ-038 Random sweep N = 5, M = 7, both modes, random out_ready -> every P matches the reference product; issue interval >= M+2.
